instr_fetch_unit: RTL and testbench

Consumer side of the program-counter interface in the multi-cycle 16-bit CPU. The block samples the current PC and issues a read to instruction memory using a req/ack handshake. It latches the returned word into the instruction register and pulses inc_pc back to the PC so the next fetch sees PC+1. It also handles redirects (pc_src), halt, and memory timeout, so the control FSM only sees clean ir_valid pulses.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/instr_fetch_unit_if.sv | 33 +++
 rtl/fetch_timer.sv | 51 +++++
 rtl/instr_fetch_unit.sv | 173 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the multi-cycle 16-bit CPU: datapath widths used by
// the PC, the instruction memory and the fetch unit, the default memory
// timeout, and the fetch unit state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int ADDR_W          = 8;
    localparam int DATA_W          = 16;
    localparam int DEFAULT_TIMEOUT = 15;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        DRAIN,
        HALTED,
        ERROR
    } fetch_state_t;

    // True for the two states that hold a request open on the memory bus.
    function automatic logic isBusState(fetch_state_t s);
        return (s == REQ) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
// Instruction-memory read bus between the fetch unit (master) and the
// instruction memory (slave).
//   imem_req   : read request, held by the master until acknowledged
//   imem_addr  : read address, stable while imem_req is high
//   imem_ack   : one-cycle completion strobe from memory
//   imem_rdata : instruction word, valid in the imem_ack cycle
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if
    import cpu_pkg::*;
    ();

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_timer.sv
// ---------------------------------------------------------------------------
// fetch_timer
// Counts cycles spent waiting on the instruction memory. expired_o is raised
// in the cycle in which the TIMEOUT-th consecutive waiting cycle occurs, so
// the FSM leaves on that edge unless an ack arrives in the same cycle.
// With TIMEOUT = 0 no counter exists and expired_o is tied low.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear_i    : zero the count (takes priority over enable_i)
//   enable_i   : count this cycle
//   expired_o  : timeout reached in this cycle
// ---------------------------------------------------------------------------
module fetch_timer
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    generate
        if (TIMEOUT > 0) begin : gen_timer
            localparam int CNT_W = $clog2(TIMEOUT + 1);

            logic [CNT_W-1:0] count_q;

            // The count holds the number of waiting cycles already completed,
            // saturating so it can never wrap back to zero.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    count_q <= '0;
                end else if (clear_i) begin
                    count_q <= '0;
                end else if (enable_i && (count_q != CNT_W'(TIMEOUT))) begin
                    count_q <= count_q + CNT_W'(1);
                end
            end

            assign expired_o = enable_i && (count_q == CNT_W'(TIMEOUT - 1));
        end else begin : gen_no_timer
            logic unused_inputs;
            assign unused_inputs = clear_i ^ enable_i ^ clk ^ reset;
            assign expired_o     = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Consumer side of the program-counter interface. Samples the PC, issues a
// read to instruction memory over a req/ack handshake, latches the word into
// the instruction register and pulses inc_pc so the next fetch sees PC+1.
// Redirects and halts that arrive while a read is outstanding let the read
// finish (DRAIN) and throw its data away; a memory that never answers sends
// the unit into a sticky ERROR state.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   fetch_en    : request next instruction (level, sampled in IDLE)
//   halt        : CPU halt (same signal that freezes the PC)
//   redirect    : pc_src pulse; the PC loads its new target on this edge
//   pc          : current PC value
//   inc_pc      : one-cycle pulse to the PC increment input
//   bus         : instruction memory bus (master side)
//   ir          : instruction register, last good fetch
//   ir_valid    : one-cycle pulse, ir updated this cycle
//   fetch_busy  : high in REQ, DRAIN and RESP
//   fetch_err   : sticky timeout error, cleared only by reset
// ---------------------------------------------------------------------------
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fetch_en,
    input  logic                halt,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   pc,
    output logic                inc_pc,
    instr_fetch_unit_if.master  bus,
    output logic [DATA_W-1:0]   ir,
    output logic                ir_valid,
    output logic                fetch_busy,
    output logic                fetch_err
);

    fetch_state_t      state_q;
    logic              imem_req_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [DATA_W-1:0] ir_q;
    logic              ir_valid_q;
    logic              inc_pc_q;
    logic              fetch_busy_q;
    logic              fetch_err_q;

    logic inBus;
    logic abandonReq;
    logic timerClear;
    logic timerEnable;
    logic timerExpired;

    // The timer only runs while a request is open and unanswered. It restarts
    // whenever an ack arrives, whenever we are outside REQ/DRAIN (so entry
    // into either always starts from zero) and on the REQ->DRAIN hand-over.
    assign inBus       = isBusState(state_q);
    assign abandonReq  = (state_q == REQ) && (halt || redirect);
    assign timerEnable = inBus && !bus.imem_ack;
    assign timerClear  = !inBus || bus.imem_ack || abandonReq;

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (timerClear),
        .enable_i  (timerEnable),
        .expired_o (timerExpired)
    );

    // Fetch FSM with all outputs registered. ir_valid and inc_pc are set only
    // on the transition into RESP, so the PC can never be bumped twice or in
    // the same cycle a redirect is honoured. In REQ, halt and redirect outrank
    // a coincident ack: that data belongs to an address the CPU no longer
    // wants. In DRAIN the decision to halt or reissue is taken from the halt
    // level seen at the ack, and the reissue address is the already-updated pc.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            imem_req_q   <= 1'b0;
            imem_addr_q  <= '0;
            ir_q         <= '0;
            ir_valid_q   <= 1'b0;
            inc_pc_q     <= 1'b0;
            fetch_busy_q <= 1'b0;
            fetch_err_q  <= 1'b0;
        end else begin
            ir_valid_q <= 1'b0;
            inc_pc_q   <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (halt) begin
                        state_q <= HALTED;
                    end else if (fetch_en) begin
                        state_q      <= REQ;
                        imem_req_q   <= 1'b1;
                        imem_addr_q  <= pc;
                        fetch_busy_q <= 1'b1;
                    end
                end

                REQ: begin
                    if (halt || redirect) begin
                        state_q <= DRAIN;
                    end else if (bus.imem_ack) begin
                        state_q    <= RESP;
                        imem_req_q <= 1'b0;
                        ir_q       <= bus.imem_rdata;
                        ir_valid_q <= 1'b1;
                        inc_pc_q   <= 1'b1;
                    end else if (timerExpired) begin
                        state_q      <= ERROR;
                        imem_req_q   <= 1'b0;
                        fetch_busy_q <= 1'b0;
                        fetch_err_q  <= 1'b1;
                    end
                end

                RESP: begin
                    state_q      <= IDLE;
                    fetch_busy_q <= 1'b0;
                end

                DRAIN: begin
                    if (bus.imem_ack) begin
                        if (halt) begin
                            state_q      <= HALTED;
                            imem_req_q   <= 1'b0;
                            fetch_busy_q <= 1'b0;
                        end else begin
                            state_q     <= REQ;
                            imem_addr_q <= pc;
                        end
                    end else if (timerExpired) begin
                        state_q      <= ERROR;
                        imem_req_q   <= 1'b0;
                        fetch_busy_q <= 1'b0;
                        fetch_err_q  <= 1'b1;
                    end
                end

                HALTED: begin
                    if (!halt) begin
                        state_q <= IDLE;
                    end
                end

                ERROR: begin
                    state_q <= ERROR;
                end

                default: begin
                    state_q      <= IDLE;
                    imem_req_q   <= 1'b0;
                    fetch_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = imem_addr_q;
    assign ir            = ir_q;
    assign ir_valid      = ir_valid_q;
    assign inc_pc        = inc_pc_q;
    assign fetch_busy    = fetch_busy_q;
    assign fetch_err     = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
// Bench for instr_fetch_unit. The bench owns the PC (increment on inc_pc,
// load on redirect) and plays the instruction memory.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    logic              clk;
    logic              reset;
    logic              fetch_en;
    logic              halt;
    logic              redirect;
    logic [ADDR_W-1:0] pc;
    logic              inc_pc;
    logic [DATA_W-1:0] ir;
    logic              ir_valid;
    logic              fetch_busy;
    logic              fetch_err;

    logic [ADDR_W-1:0] redirectTarget;
    logic [DATA_W-1:0] lastIr;
    int                checkCount;
    int                errorCount;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .TIMEOUT (15)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_en   (fetch_en),
        .halt       (halt),
        .redirect   (redirect),
        .pc         (pc),
        .inc_pc     (inc_pc),
        .bus        (bus),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .fetch_busy (fetch_busy),
        .fetch_err  (fetch_err)
    );

    typedef struct {
        logic [ADDR_W-1:0] pcVal;
        int                ackDelay;
        logic [DATA_W-1:0] rdata;
        logic [ADDR_W-1:0] expAddr;
        logic [DATA_W-1:0] expIr;
        logic [ADDR_W-1:0] expPcNext;
    } vec_t;

    vec_t vectors [4];

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the DUT wedges the bench somewhere unexpected.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Advance one clock. The PC model reacts to what it saw during the cycle
    // that just ended; single-cycle strobes are cleared for the new cycle.
    // Returns #1 after the edge, where outputs are sampled and inputs driven.
    task automatic step();
        logic incSeen;
        logic redSeen;
        incSeen = inc_pc;
        redSeen = redirect;
        @(posedge clk);
        #1;
        if (redSeen) pc = redirectTarget;
        else if (incSeen) pc = pc + 8'd1;
        redirect     = 1'b0;
        bus.imem_ack = 1'b0;
    endtask

    task automatic resetDut();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    // One complete fetch from IDLE described by a table record.
    task automatic applyStimulus(input vec_t v);
        pc       = v.pcVal;
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        for (int i = 0; i < v.ackDelay; i++) begin
            checkOutput("vec wait req", bus.imem_req, 1'b1);
            checkOutput("vec wait addr", bus.imem_addr, v.expAddr);
            checkOutput("vec wait inc_pc", inc_pc, 1'b0);
            step();
        end
        checkOutput("vec ack req", bus.imem_req, 1'b1);
        checkOutput("vec ack addr", bus.imem_addr, v.expAddr);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = v.rdata;
        step();
        checkOutput("vec ir_valid", ir_valid, 1'b1);
        checkOutput("vec inc_pc", inc_pc, 1'b1);
        checkOutput("vec ir", ir, v.expIr);
        checkOutput("vec req low", bus.imem_req, 1'b0);
        step();
        checkOutput("vec ir_valid end", ir_valid, 1'b0);
        checkOutput("vec inc_pc end", inc_pc, 1'b0);
        checkOutput("vec busy end", fetch_busy, 1'b0);
        checkOutput("vec pc next", pc, v.expPcNext);
    endtask

    initial begin
        logic [DATA_W-1:0] mem [256];
        logic [ADDR_W-1:0] expAddr;
        int                waitCnt;
        int                ackLimit;
        int                deliveries;

        checkCount     = 0;
        errorCount     = 0;
        reset          = 1'b0;
        fetch_en       = 1'b0;
        halt           = 1'b0;
        redirect       = 1'b0;
        pc             = '0;
        redirectTarget = '0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;

        vectors[0] = '{pcVal: 8'h08, ackDelay: 0,  rdata: 16'hA5A5,
                       expAddr: 8'h08, expIr: 16'hA5A5, expPcNext: 8'h09};
        vectors[1] = '{pcVal: 8'h7F, ackDelay: 3,  rdata: 16'h0F0F,
                       expAddr: 8'h7F, expIr: 16'h0F0F, expPcNext: 8'h80};
        vectors[2] = '{pcVal: 8'hFF, ackDelay: 14, rdata: 16'hFFFF,
                       expAddr: 8'hFF, expIr: 16'hFFFF, expPcNext: 8'h00};
        vectors[3] = '{pcVal: 8'h3C, ackDelay: 1,  rdata: 16'h0001,
                       expAddr: 8'h3C, expIr: 16'h0001, expPcNext: 8'h3D};

        // Reset values.
        #1 reset = 1'b1;
        #2;
        checkOutput("reset req", bus.imem_req, 1'b0);
        checkOutput("reset addr", bus.imem_addr, 8'h00);
        checkOutput("reset ir", ir, 16'h0000);
        checkOutput("reset ir_valid", ir_valid, 1'b0);
        checkOutput("reset inc_pc", inc_pc, 1'b0);
        checkOutput("reset busy", fetch_busy, 1'b0);
        checkOutput("reset err", fetch_err, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Back-to-back fetches with fetch_en held and same-cycle acks.
        pc       = 8'h00;
        fetch_en = 1'b1;
        step();
        checkOutput("basic c1 req", bus.imem_req, 1'b1);
        checkOutput("basic c1 addr", bus.imem_addr, 8'h00);
        checkOutput("basic c1 busy", fetch_busy, 1'b1);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'h1234;
        step();
        checkOutput("basic c2 ir_valid", ir_valid, 1'b1);
        checkOutput("basic c2 inc_pc", inc_pc, 1'b1);
        checkOutput("basic c2 ir", ir, 16'h1234);
        step();
        checkOutput("basic c3 req", bus.imem_req, 1'b0);
        checkOutput("basic c3 ir_valid", ir_valid, 1'b0);
        step();
        checkOutput("basic c4 req", bus.imem_req, 1'b1);
        checkOutput("basic c4 addr", bus.imem_addr, 8'h01);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'h5678;
        step();
        checkOutput("basic c5 ir_valid", ir_valid, 1'b1);
        checkOutput("basic c5 ir", ir, 16'h5678);
        fetch_en = 1'b0;
        step();
        checkOutput("basic pc", pc, 8'h02);

        // Table of single fetches with varying latency.
        foreach (vectors[i]) applyStimulus(vectors[i]);
        lastIr = 16'h0001;

        // Redirect during the second wait cycle.
        pc       = 8'h05;
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        checkOutput("redir addr", bus.imem_addr, 8'h05);
        step();
        redirect       = 1'b1;
        redirectTarget = 8'h40;
        step();
        checkOutput("redir drain req", bus.imem_req, 1'b1);
        checkOutput("redir drain addr", bus.imem_addr, 8'h05);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'hDEAD;
        step();
        checkOutput("redir no ir_valid", ir_valid, 1'b0);
        checkOutput("redir no inc_pc", inc_pc, 1'b0);
        checkOutput("redir ir kept", ir, lastIr);
        checkOutput("redir reissue req", bus.imem_req, 1'b1);
        checkOutput("redir reissue addr", bus.imem_addr, 8'h40);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'hBEEF;
        step();
        checkOutput("redir ir_valid", ir_valid, 1'b1);
        checkOutput("redir ir", ir, 16'hBEEF);
        step();
        checkOutput("redir pc", pc, 8'h41);

        // Redirect and ack in the same cycle.
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        checkOutput("redir2 addr", bus.imem_addr, 8'h41);
        redirect       = 1'b1;
        redirectTarget = 8'h80;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'hDEAD;
        step();
        checkOutput("redir2 no ir_valid", ir_valid, 1'b0);
        checkOutput("redir2 no inc_pc", inc_pc, 1'b0);
        checkOutput("redir2 ir kept", ir, 16'hBEEF);
        checkOutput("redir2 drain req", bus.imem_req, 1'b1);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'h1111;
        step();
        checkOutput("redir2 reissue addr", bus.imem_addr, 8'h80);
        checkOutput("redir2 ir still kept", ir, 16'hBEEF);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'hCAFE;
        step();
        checkOutput("redir2 ir_valid", ir_valid, 1'b1);
        checkOutput("redir2 ir", ir, 16'hCAFE);
        step();

        // Halt during a wait, then ack: data dropped, unit parks.
        pc       = 8'h10;
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        step();
        halt = 1'b1;
        step();
        checkOutput("halt drain req", bus.imem_req, 1'b1);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'hDEAD;
        step();
        checkOutput("halt req low", bus.imem_req, 1'b0);
        checkOutput("halt no ir_valid", ir_valid, 1'b0);
        checkOutput("halt ir kept", ir, 16'hCAFE);
        fetch_en = 1'b1;
        step();
        step();
        checkOutput("halted ignores fetch_en", bus.imem_req, 1'b0);
        checkOutput("halted busy", fetch_busy, 1'b0);
        halt = 1'b0;
        step();
        checkOutput("unhalt idle req", bus.imem_req, 1'b0);
        step();
        checkOutput("resume req", bus.imem_req, 1'b1);
        checkOutput("resume addr", bus.imem_addr, 8'h10);
        fetch_en       = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'h2222;
        step();
        checkOutput("resume ir", ir, 16'h2222);
        step();

        // Randomised run against a transaction-level model: every delivered
        // word must be mem[] at the address the program counter implies,
        // which advances by one per delivery and jumps on each redirect.
        foreach (mem[i]) mem[i] = 16'($urandom);
        pc         = 8'($urandom);
        expAddr    = pc;
        waitCnt    = 0;
        ackLimit   = $urandom_range(0, 4);
        deliveries = 0;
        fetch_en   = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            step();
            if (ir_valid) begin
                checkOutput("rand ir", ir, mem[expAddr]);
                expAddr = expAddr + 8'd1;
                deliveries++;
            end
            if (bus.imem_req) begin
                if (waitCnt >= ackLimit) begin
                    bus.imem_ack   = 1'b1;
                    bus.imem_rdata = mem[bus.imem_addr];
                    waitCnt        = 0;
                    ackLimit       = $urandom_range(0, 4);
                end else begin
                    waitCnt++;
                    if ($urandom_range(0, 5) == 0) begin
                        redirectTarget = 8'($urandom);
                        redirect       = 1'b1;
                        expAddr        = redirectTarget;
                    end
                end
            end else begin
                waitCnt = 0;
            end
        end
        fetch_en = 1'b0;
        checkOutput("rand enough deliveries", 32'(deliveries >= 40), 32'd1);
        checkOutput("rand no err", fetch_err, 1'b0);
        resetDut();

        // Ack arriving in the 15th waiting cycle still completes normally.
        pc       = 8'h20;
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        for (int k = 1; k < 15; k++) step();
        checkOutput("to15 req", bus.imem_req, 1'b1);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'h3333;
        step();
        checkOutput("to15 ir_valid", ir_valid, 1'b1);
        checkOutput("to15 ir", ir, 16'h3333);
        checkOutput("to15 no err", fetch_err, 1'b0);
        step();

        // Memory never answers: request held 15 cycles, then sticky error.
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            checkOutput("timeout req held", bus.imem_req, 1'b1);
            step();
        end
        checkOutput("timeout req dropped", bus.imem_req, 1'b0);
        checkOutput("timeout err", fetch_err, 1'b1);
        checkOutput("timeout busy", fetch_busy, 1'b0);
        fetch_en = 1'b1;
        step();
        step();
        step();
        checkOutput("error ignores fetch_en", bus.imem_req, 1'b0);
        checkOutput("error sticky", fetch_err, 1'b1);
        fetch_en = 1'b0;
        resetDut();
        checkOutput("error cleared by reset", fetch_err, 1'b0);

        // Asynchronous reset in the middle of a fetch.
        pc       = 8'h2F;
        fetch_en = 1'b1;
        step();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'h4444;
        step();
        checkOutput("pre-reset ir", ir, 16'h4444);
        step();
        step();
        checkOutput("pre-reset req", bus.imem_req, 1'b1);
        checkOutput("pre-reset addr", bus.imem_addr, 8'h30);
        fetch_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset req", bus.imem_req, 1'b0);
        checkOutput("async reset addr", bus.imem_addr, 8'h00);
        checkOutput("async reset ir", ir, 16'h0000);
        checkOutput("async reset ir_valid", ir_valid, 1'b0);
        checkOutput("async reset inc_pc", inc_pc, 1'b0);
        checkOutput("async reset busy", fetch_busy, 1'b0);
        checkOutput("async reset err", fetch_err, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'h9999;
        step();
        checkOutput("late ack no ir_valid", ir_valid, 1'b0);
        checkOutput("late ack ir", ir, 16'h0000);
        checkOutput("late ack req", bus.imem_req, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
